// File: rtl/thunder_packet_parser.sv
// TSIP framer for the Thunderbolt GPSDO byte stream: extracts the 0x8F-AB primary timing packet.
// Optional macro THUNDER_RANGE_CHECK_EN rejects out-of-range date/time fields at commit.
module thunder_packet_parser #(
  parameter int unsigned DATA_LEN = 17
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_dv,
  input  logic [7:0]  i_rx_byte,
  output logic        o_packet_dv,
  output logic [15:0] o_year,
  output logic [7:0]  o_month,
  output logic [7:0]  o_day,
  output logic [7:0]  o_hour,
  output logic [7:0]  o_minutes,
  output logic [7:0]  o_seconds,
  output logic [7:0]  o_timing_flag,
  output logic        o_frame_err
);

  localparam int unsigned IDX_W = $clog2(DATA_LEN + 1);

  localparam logic [7:0] DLE         = 8'h10;
  localparam logic [7:0] ETX         = 8'h03;
  localparam logic [7:0] ID_TIMING   = 8'h8F;
  localparam logic [7:0] SUB_PRIMARY = 8'hAB;

  localparam logic [IDX_W-1:0] IDX_FIRST   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_FLAG    = IDX_W'(9);
  localparam logic [IDX_W-1:0] IDX_SEC     = IDX_W'(10);
  localparam logic [IDX_W-1:0] IDX_MIN     = IDX_W'(11);
  localparam logic [IDX_W-1:0] IDX_HOUR    = IDX_W'(12);
  localparam logic [IDX_W-1:0] IDX_DAY     = IDX_W'(13);
  localparam logic [IDX_W-1:0] IDX_MONTH   = IDX_W'(14);
  localparam logic [IDX_W-1:0] IDX_YEAR_HI = IDX_W'(15);
  localparam logic [IDX_W-1:0] IDX_YEAR_LO = IDX_W'(16);
  localparam logic [IDX_W-1:0] IDX_FULL    = IDX_W'(DATA_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ID,
    ST_SUB,
    ST_DATA,
    ST_DATA_DLE,
    ST_SKIP,
    ST_SKIP_DLE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [7:0]  sh_flag_q, sh_flag_d;
  logic [7:0]  sh_sec_q, sh_sec_d;
  logic [7:0]  sh_min_q, sh_min_d;
  logic [7:0]  sh_hour_q, sh_hour_d;
  logic [7:0]  sh_day_q, sh_day_d;
  logic [7:0]  sh_month_q, sh_month_d;
  logic [15:0] sh_year_q, sh_year_d;

  logic        packet_dv_q, packet_dv_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] year_q, year_d;
  logic [7:0]  month_q, month_d;
  logic [7:0]  day_q, day_d;
  logic [7:0]  hour_q, hour_d;
  logic [7:0]  minutes_q, minutes_d;
  logic [7:0]  seconds_q, seconds_d;
  logic [7:0]  timing_flag_q, timing_flag_d;

  logic       wr_en_c;
  logic [7:0] wr_data_c;
  logic       commit_c;
  logic       fields_ok_c;

`ifdef THUNDER_RANGE_CHECK_EN
  assign fields_ok_c = (sh_sec_q <= 8'd60) && (sh_min_q <= 8'd59) && (sh_hour_q <= 8'd23) &&
                       (sh_day_q >= 8'd1) && (sh_day_q <= 8'd31) &&
                       (sh_month_q >= 8'd1) && (sh_month_q <= 8'd12) &&
                       (sh_year_q >= 16'd2000) && (sh_year_q <= 16'd2099);
`else
  assign fields_ok_c = 1'b1;
`endif

  // Framing FSM, shadow capture and commit of shadows into the output registers
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sh_flag_d     = sh_flag_q;
    sh_sec_d      = sh_sec_q;
    sh_min_d      = sh_min_q;
    sh_hour_d     = sh_hour_q;
    sh_day_d      = sh_day_q;
    sh_month_d    = sh_month_q;
    sh_year_d     = sh_year_q;
    year_d        = year_q;
    month_d       = month_q;
    day_d         = day_q;
    hour_d        = hour_q;
    minutes_d     = minutes_q;
    seconds_d     = seconds_q;
    timing_flag_d = timing_flag_q;
    packet_dv_d   = 1'b0;
    frame_err_d   = 1'b0;
    wr_en_c       = 1'b0;
    wr_data_c     = i_rx_byte;
    commit_c      = 1'b0;

    if (i_rx_dv) begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_rx_byte == DLE) state_d = ST_ID;
        end
        ST_ID: begin
          if (i_rx_byte == ID_TIMING) state_d = ST_SUB;
          else if (i_rx_byte != DLE)  state_d = ST_SKIP;
        end
        ST_SUB: begin
          if (i_rx_byte == SUB_PRIMARY) begin
            state_d = ST_DATA;
            idx_d   = IDX_FIRST;
          end else if (i_rx_byte == DLE) begin
            state_d = ST_SKIP_DLE;
          end else begin
            state_d = ST_SKIP;
          end
        end
        ST_DATA: begin
          if (i_rx_byte == DLE) begin
            state_d = ST_DATA_DLE;
          end else if (idx_q == IDX_FULL) begin
            frame_err_d = 1'b1;
            state_d     = ST_SKIP;
          end else begin
            wr_en_c = 1'b1;
          end
        end
        ST_DATA_DLE: begin
          // A stuffed DLE is a data byte, so it is also subject to the length limit
          if (i_rx_byte == DLE) begin
            if (idx_q == IDX_FULL) begin
              frame_err_d = 1'b1;
              state_d     = ST_SKIP;
            end else begin
              wr_en_c   = 1'b1;
              wr_data_c = DLE;
              state_d   = ST_DATA;
            end
          end else if (i_rx_byte == ETX) begin
            state_d = ST_IDLE;
            if ((idx_q == IDX_FULL) && fields_ok_c) commit_c    = 1'b1;
            else                                    frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = (i_rx_byte == ID_TIMING) ? ST_SUB : ST_SKIP;
          end
        end
        ST_SKIP: begin
          if (i_rx_byte == DLE) state_d = ST_SKIP_DLE;
        end
        ST_SKIP_DLE: begin
          if (i_rx_byte == ETX)            state_d = ST_IDLE;
          else if (i_rx_byte == ID_TIMING) state_d = ST_SUB;
          else                             state_d = ST_SKIP;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (wr_en_c) begin
      idx_d = idx_q + IDX_W'(1);
      case (idx_q)
        IDX_FLAG:    sh_flag_d        = wr_data_c;
        IDX_SEC:     sh_sec_d         = wr_data_c;
        IDX_MIN:     sh_min_d         = wr_data_c;
        IDX_HOUR:    sh_hour_d        = wr_data_c;
        IDX_DAY:     sh_day_d         = wr_data_c;
        IDX_MONTH:   sh_month_d       = wr_data_c;
        IDX_YEAR_HI: sh_year_d[15:8]  = wr_data_c;
        IDX_YEAR_LO: sh_year_d[7:0]   = wr_data_c;
        default: ;
      endcase
    end

    if (commit_c) begin
      packet_dv_d   = 1'b1;
      year_d        = sh_year_q;
      month_d       = sh_month_q;
      day_d         = sh_day_q;
      hour_d        = sh_hour_q;
      minutes_d     = sh_min_q;
      seconds_d     = sh_sec_q;
      timing_flag_d = sh_flag_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      sh_flag_q     <= '0;
      sh_sec_q      <= '0;
      sh_min_q      <= '0;
      sh_hour_q     <= '0;
      sh_day_q      <= '0;
      sh_month_q    <= '0;
      sh_year_q     <= '0;
      packet_dv_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      year_q        <= '0;
      month_q       <= '0;
      day_q         <= '0;
      hour_q        <= '0;
      minutes_q     <= '0;
      seconds_q     <= '0;
      timing_flag_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      sh_flag_q     <= sh_flag_d;
      sh_sec_q      <= sh_sec_d;
      sh_min_q      <= sh_min_d;
      sh_hour_q     <= sh_hour_d;
      sh_day_q      <= sh_day_d;
      sh_month_q    <= sh_month_d;
      sh_year_q     <= sh_year_d;
      packet_dv_q   <= packet_dv_d;
      frame_err_q   <= frame_err_d;
      year_q        <= year_d;
      month_q       <= month_d;
      day_q         <= day_d;
      hour_q        <= hour_d;
      minutes_q     <= minutes_d;
      seconds_q     <= seconds_d;
      timing_flag_q <= timing_flag_d;
    end
  end

  assign o_packet_dv   = packet_dv_q;
  assign o_frame_err   = frame_err_q;
  assign o_year        = year_q;
  assign o_month       = month_q;
  assign o_day         = day_q;
  assign o_hour        = hour_q;
  assign o_minutes     = minutes_q;
  assign o_seconds     = seconds_q;
  assign o_timing_flag = timing_flag_q;

endmodule

// File: tb/tb_thunder_packet_parser.sv
// Bench for thunder_packet_parser: packet-level model predicts each strobe, its cycle and the held outputs.
module tb_thunder_packet_parser;

  localparam logic [7:0] DLE = 8'h10;
  localparam logic [7:0] ETX = 8'h03;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        o_packet_dv, o_frame_err;
  logic [15:0] o_year;
  logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds, o_timing_flag;

  always #5 clk = ~clk;

  thunder_packet_parser #(.DATA_LEN(17)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte),
    .o_packet_dv(o_packet_dv), .o_year(o_year), .o_month(o_month), .o_day(o_day),
    .o_hour(o_hour), .o_minutes(o_minutes), .o_seconds(o_seconds),
    .o_timing_flag(o_timing_flag), .o_frame_err(o_frame_err)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  flag, sec, min, hour, day, mon;
    logic [15:0] year;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         pkt_ev;
  logic [7:0]  pl[$];
  logic [7:0]  pkt[$];
  int          trig, trig_long, trig_bad;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [63:0] m_view = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare: strobes must land exactly on predicted cycles, outputs must hold otherwise
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      m_view = '0;
      chk("rst_strobes", 64'({o_packet_dv, o_frame_err}), 64'(0));
      chk("rst_fields", {o_year, o_month, o_day, o_hour, o_minutes, o_seconds, o_timing_flag}, 64'(0));
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("packet_dv", 64'(o_packet_dv), 64'(!e.is_err));
        chk("frame_err", 64'(o_frame_err), 64'(e.is_err));
        if (!e.is_err) m_view = {e.year, e.mon, e.day, e.hour, e.min, e.sec, e.flag};
      end else begin
        chk("no_strobe", 64'({o_packet_dv, o_frame_err}), 64'(0));
      end
      chk("held_fields", {o_year, o_month, o_day, o_hour, o_minutes, o_seconds, o_timing_flag}, m_view);
    end
  end

  function automatic logic [7:0] rnd_byte();
    if ($urandom_range(0, 3) == 0) return DLE;
    return 8'($urandom);
  endfunction

  function automatic bit fields_ok(input ev_t e);
    return e.sec <= 60 && e.min <= 59 && e.hour <= 23 && e.day >= 1 && e.day <= 31 &&
           e.mon >= 1 && e.mon <= 12 && e.year >= 2000 && e.year <= 2099;
  endfunction

  task automatic push_stuffed(input logic [7:0] b);
    pkt.push_back(b);
    if (b == DLE) pkt.push_back(b);
  endtask

  // Build the wire bytes from pl; optionally inject an illegal DLE escape before data byte bad_at
  task automatic frame(input logic [7:0] id, input logic [7:0] sub, input int bad_at, input logic [7:0] bad_b);
    pkt.delete();
    trig_long = -1;
    trig_bad  = -1;
    pkt.push_back(DLE);
    push_stuffed(id);
    push_stuffed(sub);
    for (int i = 0; i < pl.size(); i++) begin
      if (i == bad_at) begin
        pkt.push_back(DLE);
        pkt.push_back(bad_b);
        trig_bad = pkt.size() - 1;
      end
      push_stuffed(pl[i]);
      if (i == 16) trig_long = pkt.size() - 1;
    end
    pkt.push_back(DLE);
    pkt.push_back(ETX);
  endtask

  task automatic make_ab(input logic [7:0] flag, sec, min, hour, day, mon, input logic [15:0] year);
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(rnd_byte());
    pl.push_back(flag); pl.push_back(sec); pl.push_back(min); pl.push_back(hour);
    pl.push_back(day);  pl.push_back(mon); pl.push_back(year[15:8]); pl.push_back(year[7:0]);
  endtask

  // Outcome of a framed 0x8F-AB packet, decided from its de-stuffed length and field values
  task automatic expect_ab();
    pkt_ev = '{default: 0};
    if (trig_bad >= 0) begin
      pkt_ev.is_err = 1; trig = trig_bad;
    end else if (pl.size() > 16) begin
      pkt_ev.is_err = 1; trig = trig_long;
    end else if (pl.size() < 16) begin
      pkt_ev.is_err = 1; trig = pkt.size() - 1;
    end else begin
      trig = pkt.size() - 1;
      pkt_ev.flag = pl[8];  pkt_ev.sec = pl[9];  pkt_ev.min = pl[10]; pkt_ev.hour = pl[11];
      pkt_ev.day  = pl[12]; pkt_ev.mon = pl[13]; pkt_ev.year = {pl[14], pl[15]};
`ifdef THUNDER_RANGE_CHECK_EN
      pkt_ev.is_err = !fields_ok(pkt_ev);
`endif
    end
  endtask

  task automatic send_pkt(input int idle, input int upto);
    int n;
    int last;
    last = (upto < 0) ? pkt.size() : upto;
    for (int i = 0; i < last; i++) begin
      @(posedge clk); #2;
      rx_dv   = 1'b1;
      rx_byte = pkt[i];
      if (i == trig) begin
        ev_t e;
        e = pkt_ev;
        e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
      n = (idle < 0) ? int'($urandom_range(0, 2)) : idle;
      repeat (n) begin
        @(posedge clk); #2;
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      rx_dv = 1'b0;
    end
  endtask

  task automatic send_gap(input int n);
    repeat (n) begin
      @(posedge clk); #2;
      rx_dv   = 1'b1;
      rx_byte = 8'($urandom_range(0, 255));
      if (rx_byte == DLE) rx_byte = 8'h11;
    end
  endtask

  task automatic run_ab(input logic [7:0] flag, sec, min, hour, day, mon, input logic [15:0] year, input int idle);
    make_ab(flag, sec, min, hour, day, mon, year);
    frame(8'h8F, 8'hAB, -1, 8'h00);
    expect_ab();
    send_pkt(idle, -1);
  endtask

  task automatic run_foreign(input logic [7:0] id, input logic [7:0] sub, input int idle);
    frame(id, sub, -1, 8'h00);
    trig = -1;
    send_pkt(idle, -1);
  endtask

  task automatic chk_time(input string name, input logic [15:0] y, input logic [7:0] mo, d, h, mi, s, f);
    idle_cycles(3);
    chk({name, "_year"}, 64'(o_year), 64'(y));
    chk({name, "_month"}, 64'(o_month), 64'(mo));
    chk({name, "_day"}, 64'(o_day), 64'(d));
    chk({name, "_hms"}, 64'({o_hour, o_minutes, o_seconds}), 64'({h, mi, s}));
    chk({name, "_flag"}, 64'(o_timing_flag), 64'(f));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0]  s, mi, h, d, mo, f;
    logic [15:0] y;
    int          kind, n;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    chk_time("reset", 16'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    // Nominal packet, bytes 10 clocks apart
    run_ab(8'h03, 8'd28, 8'd55, 8'd11, 8'd15, 8'd7, 16'd2020, 9);
    chk_time("nominal", 16'd2020, 8'd7, 8'd15, 8'd11, 8'd55, 8'd28, 8'h03);

    // Stuffing: seconds 16, TOW byte 0x10
    make_ab(8'h01, 8'd16, 8'd0, 8'd1, 8'd2, 8'd3, 16'h07E4);
    pl[1] = DLE;
    frame(8'h8F, 8'hAB, -1, 8'h00);
    expect_ab();
    send_pkt(0, -1);
    chk_time("stuffed", 16'h07E4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd16, 8'h01);

    // Foreign packets with stuffed DLE ETX inside, then a valid packet, all back to back
    pl = '{8'h01, DLE, ETX, DLE, DLE, 8'h8F, 8'h03};
    run_foreign(8'h8F, 8'hAC, 0);
    pl = '{DLE, ETX, 8'h22};
    run_foreign(8'h47, 8'h05, 0);
    run_ab(8'h01, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 16'd2021, 0);
    chk_time("after_foreign", 16'd2021, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'h01);

    // Length errors keep the previous time
    run_ab(8'h03, 8'd28, 8'd55, 8'd11, 8'd15, 8'd7, 16'd2020, 1);
    make_ab(8'h03, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 16'd2001);
    pl = pl[0:14];
    frame(8'h8F, 8'hAB, -1, 8'h00);
    expect_ab();
    send_pkt(1, -1);
    make_ab(8'h03, 8'd2, 8'd2, 8'd2, 8'd2, 8'd2, 16'd2002);
    pl.push_back(8'h44); pl.push_back(8'h55);
    frame(8'h8F, 8'hAB, -1, 8'h00);
    expect_ab();
    send_pkt(1, -1);
    chk_time("len_err", 16'd2020, 8'd7, 8'd15, 8'd11, 8'd55, 8'd28, 8'h03);

    // Reset after byte 12 of a packet, then a clean packet
    make_ab(8'h03, 8'd29, 8'd55, 8'd11, 8'd15, 8'd7, 16'd2020);
    frame(8'h8F, 8'hAB, -1, 8'h00);
    expect_ab();
    send_pkt(1, 12);
    @(posedge clk); #2;
    rx_dv = 1'b0;
    rst   = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    run_ab(8'h03, 8'd29, 8'd55, 8'd11, 8'd15, 8'd7, 16'd2020, 1);
    chk_time("post_reset", 16'd2020, 8'd7, 8'd15, 8'd11, 8'd55, 8'd29, 8'h03);

    // Month 13
    run_ab(8'h03, 8'd28, 8'd55, 8'd11, 8'd15, 8'd13, 16'd2020, 1);
`ifdef THUNDER_RANGE_CHECK_EN
    chk_time("month13", 16'd2020, 8'd7, 8'd15, 8'd11, 8'd55, 8'd29, 8'h03);
`else
    chk_time("month13", 16'd2020, 8'd13, 8'd15, 8'd11, 8'd55, 8'd28, 8'h03);
`endif

    // Randomized mix of valid, malformed and foreign packets
    for (int it = 0; it < 160; it++) begin
      kind = $urandom_range(0, 9);
      s  = 8'($urandom_range(0, 60));  mi = 8'($urandom_range(0, 59));
      h  = 8'($urandom_range(0, 23));  d  = 8'($urandom_range(1, 31));
      mo = 8'($urandom_range(1, 12));  y  = 16'($urandom_range(2000, 2099));
      f  = rnd_byte();
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 5))
          0: s  = 8'($urandom_range(61, 255));
          1: mi = 8'($urandom_range(60, 255));
          2: h  = 8'($urandom_range(24, 255));
          3: d  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(32, 255));
          4: mo = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(13, 255));
          default: y = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 1999))
                                                   : 16'($urandom_range(2100, 65535));
        endcase
      end
      if (kind <= 4) begin
        run_ab(f, s, mi, h, d, mo, y, -1);
      end else if (kind == 5) begin
        make_ab(f, s, mi, h, d, mo, y);
        n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(17, 20));
        while (pl.size() > n) void'(pl.pop_back());
        while (pl.size() < n) pl.push_back(rnd_byte());
        frame(8'h8F, 8'hAB, -1, 8'h00);
        expect_ab();
        send_pkt(-1, -1);
      end else if (kind == 6) begin
        make_ab(f, s, mi, h, d, mo, y);
        n = $urandom_range(0, 255);
        if (n == 8'h10 || n == 8'h03 || n == 8'h8F) n = 8'h55;
        frame(8'h8F, 8'hAB, int'($urandom_range(0, 15)), 8'(n));
        expect_ab();
        send_pkt(-1, -1);
      end else begin
        pl.delete();
        n = $urandom_range(0, 24);
        for (int i = 0; i < n; i++) pl.push_back(rnd_byte());
        if (kind == 7) begin
          n = $urandom_range(0, 255);
          if (n == 8'hAB) n = 8'hAC;
          run_foreign(8'h8F, 8'(n), -1);
        end else begin
          n = $urandom_range(0, 255);
          if (n == 8'h8F || n == 8'h10) n = 8'h47;
          run_foreign(8'(n), rnd_byte(), -1);
        end
      end
      send_gap($urandom_range(0, 3));
    end

    idle_cycles(5);
    chk("pending_events", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
